// File: rtl/rename_stage_if.sv
// Bundles the decode-side, dispatch-side, commit and branch signals of the rename stage.
// The environment uses the master modport and rename_stage uses the slave modport.
interface rename_stage_if;

  typedef struct packed {
    logic [6:0]  ps1;
    logic [6:0]  ps2;
    logic [6:0]  pd_new;
    logic [6:0]  pd_old;
    logic [1:0]  fu;
    logic [63:0] payload;
  } rename_data;

  logic        valid_in;
  logic        ready_in;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        writes_rd;
  logic [1:0]  fu_in;
  logic [63:0] payload_in;
  logic        valid_out;
  logic        ready_out;
  rename_data  data_out;
  logic        commit_valid;
  logic [6:0]  commit_pd_old;
  logic        br_resolved;
  logic        mispredict;
  logic        ckpt_busy;
  logic [7:0]  free_count;

  modport master (
    output valid_in, rs1, rs2, rd, writes_rd, fu_in, payload_in, ready_out,
           commit_valid, commit_pd_old, br_resolved, mispredict,
    input  ready_in, valid_out, data_out, ckpt_busy, free_count
  );

  modport slave (
    input  valid_in, rs1, rs2, rd, writes_rd, fu_in, payload_in, ready_out,
           commit_valid, commit_pd_old, br_resolved, mispredict,
    output ready_in, valid_out, data_out, ckpt_busy, free_count
  );

endinterface

// File: rtl/rename_stage.sv
// Register-rename stage: map table lookup, free-list allocation, commit recycling
// and single-checkpoint recovery, with a registered output slot toward dispatch.
module rename_stage #(
  parameter int NUM_PREG = 128,
  parameter int NUM_AREG = 32
) (
  input logic           clk,
  input logic           reset,
  rename_stage_if.slave bus
);

  localparam logic [1:0] FU_BR = 2'b10;

  logic [6:0] map_q     [NUM_AREG];
  logic [6:0] ckpt_map  [NUM_AREG];
  logic [6:0] free_list [NUM_PREG];
  logic [7:0] head;
  logic [7:0] tail;
  logic [7:0] ckpt_head;
  logic       ckpt_busy_q;
  logic       valid_q;

  logic       alloc;
  logic       is_branch;
  logic       ready;
  logic       fire;
  logic       restore;
  logic       push;
  logic [7:0] count;
  logic [6:0] ps1;
  logic [6:0] ps2;
  logic [6:0] pd_new;
  logic [6:0] pd_old;

  // Freed registers only become visible through tail at the next edge, so a
  // same-cycle commit cannot rescue an allocation from an empty list.
  always_comb begin
    alloc     = bus.writes_rd && (bus.rd != 5'd0);
    is_branch = (bus.fu_in == FU_BR);
    count     = tail - head;
    ready     = (!valid_q || bus.ready_out) && (!alloc || count != 8'd0) &&
                !(is_branch && ckpt_busy_q) && !bus.mispredict;
    fire      = bus.valid_in && ready;
    restore   = bus.mispredict && ckpt_busy_q;
    push      = bus.commit_valid && (bus.commit_pd_old != 7'd0);
    ps1       = map_q[bus.rs1];
    ps2       = map_q[bus.rs2];
    pd_new    = alloc ? free_list[head[6:0]] : 7'd0;
    pd_old    = alloc ? map_q[bus.rd] : 7'd0;
  end

  assign bus.ready_in   = ready;
  assign bus.free_count = count;
  assign bus.ckpt_busy  = ckpt_busy_q;
  assign bus.valid_out  = valid_q;

  // The snapshot already contains the branch's own destination mapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_AREG; i++) begin
        map_q[i]    <= 7'(i);
        ckpt_map[i] <= 7'(i);
      end
    end else begin
      if (restore) begin
        for (int i = 0; i < NUM_AREG; i++) map_q[i] <= ckpt_map[i];
      end else if (fire && alloc) begin
        map_q[bus.rd] <= pd_new;
      end
      if (fire && is_branch) begin
        for (int i = 0; i < NUM_AREG; i++)
          ckpt_map[i] <= (alloc && bus.rd == 5'(i)) ? pd_new : map_q[i];
      end
    end
  end

  // Tail is never rolled back; recovery only rewinds head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PREG; i++)
        free_list[i] <= (i < NUM_PREG - NUM_AREG) ? 7'(i + NUM_AREG) : 7'd0;
      head      <= 8'd0;
      tail      <= 8'(NUM_PREG - NUM_AREG);
      ckpt_head <= 8'd0;
    end else begin
      if (push) begin
        free_list[tail[6:0]] <= bus.commit_pd_old;
        tail                 <= tail + 8'd1;
      end
      if (restore) head <= ckpt_head;
      else if (fire && alloc) head <= head + 8'd1;
      if (fire && is_branch) ckpt_head <= head + {7'd0, alloc};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ckpt_busy_q  <= 1'b0;
      valid_q      <= 1'b0;
      bus.data_out <= '0;
    end else begin
      if (bus.mispredict) ckpt_busy_q <= 1'b0;
      else if (fire && is_branch) ckpt_busy_q <= 1'b1;
      else if (bus.br_resolved) ckpt_busy_q <= 1'b0;

      if (bus.mispredict) begin
        valid_q <= 1'b0;
      end else if (fire) begin
        valid_q                <= 1'b1;
        bus.data_out.ps1       <= ps1;
        bus.data_out.ps2       <= ps2;
        bus.data_out.pd_new    <= pd_new;
        bus.data_out.pd_old    <= pd_old;
        bus.data_out.fu        <= bus.fu_in;
        bus.data_out.payload   <= bus.payload_in;
      end else if (bus.ready_out) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule
